// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register-file widths and types
// Holds the architectural register count, the data width and the address type
// used by the writeback scheduler and its arbiter.
package rf_pkg;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int REG_AW = 5;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]   xlen_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, one-hot grant
// Ports:
//   req  in  N   request vector
//   ptr  in  PW  highest-priority index this cycle
//   gnt  out N   one-hot grant (all zero when no request)
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic [N-1:0] mask;
    logic [N-1:0] masked;

    // Requests at or above ptr win first; if none, wrap to the lowest request.
    always_comb begin
        mask = '0;
        for (int i = 0; i < N; i++) begin
            mask[i] = (i >= int'(ptr));
        end
    end

    assign masked = req & mask;

    // x & -x isolates the lowest set bit.
    assign gnt = (|masked) ? (masked & (~masked + N'(1)))
                           : (req & (~req + N'(1)));

endmodule

// File: rtl/regfile_wb_scheduler.sv
// rtl/regfile_wb_scheduler.sv - regfile write-port sharing, scoreboard and issue hazard stall
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   iss_valid/iss_uses_rd/iss_rd issue-stage instruction and its destination
//   iss_rs1/2/3, iss_use_rs      sources and per-source enables {rs3,rs2,rs1}
//   iss_stall                    issue not accepted this cycle
//   wb_valid/wb_addr/wb_data     NUM_WB writeback requesters
//   wb_ready                     one-hot grant, transfer on valid&ready
//   rf_write/rf_w1_addr/rf_inp_data  registered regfile write port
//   pending                      outstanding-write scoreboard
module regfile_wb_scheduler #(
    parameter int NUM_WB = 4,
    parameter int XLEN   = 32,
    parameter int NREGS  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       iss_valid,
    input  logic                       iss_uses_rd,
    input  rf_pkg::reg_addr_t          iss_rd,
    input  rf_pkg::reg_addr_t          iss_rs1,
    input  rf_pkg::reg_addr_t          iss_rs2,
    input  rf_pkg::reg_addr_t          iss_rs3,
    input  logic [2:0]                 iss_use_rs,
    output logic                       iss_stall,
    input  logic [NUM_WB-1:0]          wb_valid,
    input  logic [NUM_WB*5-1:0]        wb_addr,
    input  logic [NUM_WB*XLEN-1:0]     wb_data,
    output logic [NUM_WB-1:0]          wb_ready,
    output logic                       rf_write,
    output rf_pkg::reg_addr_t          rf_w1_addr,
    output logic [XLEN-1:0]            rf_inp_data,
    output logic [NREGS-1:0]           pending
);

    import rf_pkg::*;

    localparam int IW = (NUM_WB > 1) ? $clog2(NUM_WB) : 1;

    logic [IW-1:0]     rr_ptr;
    logic [NUM_WB-1:0] gnt;
    logic [IW-1:0]     gnt_idx;
    logic              gnt_any;
    reg_addr_t         sel_addr;
    logic [XLEN-1:0]   sel_data;
    logic              raw_hit;
    logic              waw_hit;
    logic              iss_accept;
    logic [NREGS-1:0]  set_vec;
    logic [NREGS-1:0]  clr_vec;
    logic [NREGS-1:0]  pending_nxt;

    rr_arbiter #(.N(NUM_WB), .PW(IW)) u_arb (
        .req (wb_valid),
        .ptr (rr_ptr),
        .gnt (gnt)
    );

    // No handshakes while in reset; requesters are being reset too.
    assign wb_ready = rst ? '0 : gnt;
    assign gnt_any  = |wb_ready;

    always_comb begin
        gnt_idx  = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_WB; i++) begin
            if (wb_ready[i]) begin
                gnt_idx  = IW'(i);
                sel_addr = wb_addr[i*5 +: 5];
                sel_data = wb_data[i*XLEN +: XLEN];
            end
        end
    end

    // pending[0] is never set, so x0 sources never stall without an explicit compare.
    assign raw_hit = (iss_use_rs[0] & pending[iss_rs1]) |
                     (iss_use_rs[1] & pending[iss_rs2]) |
                     (iss_use_rs[2] & pending[iss_rs3]);
    assign waw_hit = iss_uses_rd & pending[iss_rd];

    assign iss_stall  = iss_valid & (rst | raw_hit | waw_hit);
    assign iss_accept = iss_valid & ~iss_stall;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (iss_accept && iss_uses_rd) begin
            set_vec[iss_rd] = 1'b1;
        end
        if (rf_write) begin
            clr_vec[rf_w1_addr] = 1'b1;
        end
    end

    // Set wins over clear; bit 0 forced low.
    assign pending_nxt = ((pending & ~clr_vec) | set_vec) & ~NREGS'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= '0;
            rf_write    <= 1'b0;
            rf_w1_addr  <= '0;
            rf_inp_data <= '0;
            pending     <= '0;
        end else begin
            pending <= pending_nxt;
            if (gnt_any) begin
                rr_ptr <= (gnt_idx == IW'(NUM_WB - 1)) ? '0 : gnt_idx + IW'(1);
            end
            // x0 writes complete the handshake but never reach the regfile.
            if (gnt_any && (sel_addr != '0)) begin
                rf_write    <= 1'b1;
                rf_w1_addr  <= sel_addr;
                rf_inp_data <= sel_data;
            end else begin
                rf_write    <= 1'b0;
            end
        end
    end

    // The WAW stall keeps a register from being re-issued while its write is in flight.
    a_no_set_clr_collision: assert property (@(posedge clk) disable iff (rst)
        ~|(set_vec & clr_vec));

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb/tb_regfile_wb_scheduler.sv - directed bench for regfile_wb_scheduler
module tb_regfile_wb_scheduler;

    localparam int NUM_WB = 4;
    localparam int XLEN   = 32;
    localparam int NREGS  = 32;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   iss_valid;
    logic                   iss_uses_rd;
    logic [4:0]             iss_rd;
    logic [4:0]             iss_rs1;
    logic [4:0]             iss_rs2;
    logic [4:0]             iss_rs3;
    logic [2:0]             iss_use_rs;
    logic                   iss_stall;
    logic [NUM_WB-1:0]      wb_valid;
    logic [NUM_WB*5-1:0]    wb_addr;
    logic [NUM_WB*XLEN-1:0] wb_data;
    logic [NUM_WB-1:0]      wb_ready;
    logic                   rf_write;
    logic [4:0]             rf_w1_addr;
    logic [XLEN-1:0]        rf_inp_data;
    logic [NREGS-1:0]       pending;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_wb_scheduler #(.NUM_WB(NUM_WB), .XLEN(XLEN), .NREGS(NREGS)) dut (
        .clk         (clk),
        .rst         (rst),
        .iss_valid   (iss_valid),
        .iss_uses_rd (iss_uses_rd),
        .iss_rd      (iss_rd),
        .iss_rs1     (iss_rs1),
        .iss_rs2     (iss_rs2),
        .iss_rs3     (iss_rs3),
        .iss_use_rs  (iss_use_rs),
        .iss_stall   (iss_stall),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .wb_ready    (wb_ready),
        .rf_write    (rf_write),
        .rf_w1_addr  (rf_w1_addr),
        .rf_inp_data (rf_inp_data),
        .pending     (pending)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic idle_inputs;
        iss_valid   = 1'b0;
        iss_uses_rd = 1'b0;
        iss_rd      = '0;
        iss_rs1     = '0;
        iss_rs2     = '0;
        iss_rs3     = '0;
        iss_use_rs  = '0;
        wb_valid    = '0;
        wb_addr     = '0;
        wb_data     = '0;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst         = 1'b1;
        wb_valid    = 4'b1111;
        wb_addr     = {5'd4, 5'd3, 5'd2, 5'd1};
        iss_valid   = 1'b1;
        iss_uses_rd = 1'b1;
        iss_rd      = 5'd3;
        tick();
        tick();
        settle();
        checks++; if (wb_ready !== 4'b0000) begin errors++; $display("FAIL reset_wb_ready got %b want 0000", wb_ready); end
        checks++; if (rf_write !== 1'b0) begin errors++; $display("FAIL reset_rf_write got %b want 0", rf_write); end
        checks++; if (pending !== 32'h0) begin errors++; $display("FAIL reset_pending got %h want 0", pending); end
        checks++; if (iss_stall !== 1'b1) begin errors++; $display("FAIL reset_iss_stall got %b want 1", iss_stall); end
        checks++; if (rf_w1_addr !== 5'd0 || rf_inp_data !== 32'h0) begin errors++; $display("FAIL reset_wport got %0d/%h want 0/0", rf_w1_addr, rf_inp_data); end
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_gnt;
        wb_valid = 4'b1111;
        wb_addr  = {5'd4, 5'd3, 5'd2, 5'd1};
        wb_data  = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
        settle();
        for (int k = 0; k < 4; k++) begin
            exp_gnt = 4'(1 << k);
            checks++; if (wb_ready !== exp_gnt) begin errors++; $display("FAIL rr_grant_%0d got %b want %b", k, wb_ready, exp_gnt); end
            tick();
            settle();
            checks++;
            if (rf_write !== 1'b1 || rf_w1_addr !== 5'(k + 1) || rf_inp_data !== (32'hA000_0000 + 32'(k))) begin
                errors++;
                $display("FAIL rr_write_%0d got %b/%0d/%h want 1/%0d/%h", k, rf_write, rf_w1_addr, rf_inp_data, k + 1, 32'hA000_0000 + 32'(k));
            end
        end
        wb_valid = '0;
        settle();
        checks++; if (wb_ready !== 4'b0000) begin errors++; $display("FAIL rr_idle_ready got %b want 0000", wb_ready); end
        tick();
        settle();
        checks++;
        if (rf_write !== 1'b0 || rf_w1_addr !== 5'd4 || rf_inp_data !== 32'hA000_0003) begin
            errors++;
            $display("FAIL rr_idle_hold got %b/%0d/%h want 0/4/a0000003", rf_write, rf_w1_addr, rf_inp_data);
        end
    endtask

    task automatic test_raw_stall;
        iss_valid   = 1'b1;
        iss_uses_rd = 1'b1;
        iss_rd      = 5'd5;
        iss_use_rs  = 3'b000;
        settle();
        checks++; if (iss_stall !== 1'b0) begin errors++; $display("FAIL raw_producer_stall got %b want 0", iss_stall); end
        tick();
        iss_rd     = 5'd6;
        iss_rs1    = 5'd5;
        iss_use_rs = 3'b001;
        settle();
        checks++; if (pending !== 32'h0000_0020) begin errors++; $display("FAIL raw_pending_set got %h want 00000020", pending); end
        checks++; if (iss_stall !== 1'b1) begin errors++; $display("FAIL raw_stall_0 got %b want 1", iss_stall); end
        tick();
        settle();
        checks++; if (iss_stall !== 1'b1) begin errors++; $display("FAIL raw_stall_1 got %b want 1", iss_stall); end
        wb_valid = 4'b0010;
        wb_addr[1*5 +: 5]       = 5'd5;
        wb_data[1*XLEN +: XLEN] = 32'h5555_0005;
        settle();
        checks++; if (wb_ready !== 4'b0010 || iss_stall !== 1'b1) begin errors++; $display("FAIL raw_handshake got %b/%b want 0010/1", wb_ready, iss_stall); end
        tick();
        wb_valid = '0;
        settle();
        checks++;
        if (rf_write !== 1'b1 || rf_w1_addr !== 5'd5 || rf_inp_data !== 32'h5555_0005 || iss_stall !== 1'b1) begin
            errors++;
            $display("FAIL raw_write_cycle got %b/%0d/%h stall %b want 1/5/55550005 stall 1", rf_write, rf_w1_addr, rf_inp_data, iss_stall);
        end
        tick();
        settle();
        checks++; if (iss_stall !== 1'b0 || pending !== 32'h0) begin errors++; $display("FAIL raw_release got %b/%h want 0/0", iss_stall, pending); end
        tick();
        idle_inputs();
        settle();
        checks++; if (pending !== 32'h0000_0040) begin errors++; $display("FAIL raw_consumer_set got %h want 00000040", pending); end
        wb_valid = 4'b0100;
        wb_addr[2*5 +: 5]       = 5'd6;
        wb_data[2*XLEN +: XLEN] = 32'h6666_0006;
        settle();
        checks++; if (wb_ready !== 4'b0100) begin errors++; $display("FAIL raw_clear6_grant got %b want 0100", wb_ready); end
        tick();
        wb_valid = '0;
        tick();
        settle();
        checks++; if (pending !== 32'h0) begin errors++; $display("FAIL raw_clear6 got %h want 0", pending); end
    endtask

    task automatic test_waw_stall;
        iss_valid   = 1'b1;
        iss_uses_rd = 1'b1;
        iss_rd      = 5'd7;
        iss_use_rs  = 3'b000;
        settle();
        checks++; if (iss_stall !== 1'b0) begin errors++; $display("FAIL waw_first_issue got %b want 0", iss_stall); end
        tick();
        settle();
        checks++; if (pending !== 32'h0000_0080 || iss_stall !== 1'b1) begin errors++; $display("FAIL waw_stall_0 got %h/%b want 00000080/1", pending, iss_stall); end
        tick();
        settle();
        checks++; if (iss_stall !== 1'b1) begin errors++; $display("FAIL waw_stall_1 got %b want 1", iss_stall); end
        wb_valid = 4'b1000;
        wb_addr[3*5 +: 5]       = 5'd7;
        wb_data[3*XLEN +: XLEN] = 32'h7777_0007;
        settle();
        checks++; if (wb_ready !== 4'b1000) begin errors++; $display("FAIL waw_grant got %b want 1000", wb_ready); end
        tick();
        wb_valid = '0;
        settle();
        checks++; if (rf_write !== 1'b1 || rf_w1_addr !== 5'd7 || iss_stall !== 1'b1) begin errors++; $display("FAIL waw_write_cycle got %b/%0d/%b want 1/7/1", rf_write, rf_w1_addr, iss_stall); end
        tick();
        settle();
        checks++; if (iss_stall !== 1'b0) begin errors++; $display("FAIL waw_release got %b want 0", iss_stall); end
        tick();
        idle_inputs();
        settle();
        checks++; if (pending !== 32'h0000_0080) begin errors++; $display("FAIL waw_reissue_set got %h want 00000080", pending); end
    endtask

    task automatic test_x0_discard;
        wb_valid = 4'b0100;
        wb_addr[2*5 +: 5]       = 5'd0;
        wb_data[2*XLEN +: XLEN] = 32'hDEAD_BEEF;
        iss_valid   = 1'b1;
        iss_uses_rd = 1'b1;
        iss_rd      = 5'd0;
        settle();
        checks++; if (wb_ready !== 4'b0100 || iss_stall !== 1'b0) begin errors++; $display("FAIL x0_grant got %b/%b want 0100/0", wb_ready, iss_stall); end
        tick();
        idle_inputs();
        settle();
        checks++;
        if (rf_write !== 1'b0 || rf_w1_addr !== 5'd7 || rf_inp_data !== 32'h7777_0007) begin
            errors++;
            $display("FAIL x0_no_write got %b/%0d/%h want 0/7/77770007", rf_write, rf_w1_addr, rf_inp_data);
        end
        checks++; if (pending !== 32'h0000_0080) begin errors++; $display("FAIL x0_pending got %h want 00000080", pending); end
        wb_valid = 4'b0001;
        wb_addr[0 +: 5]    = 5'd7;
        wb_data[0 +: XLEN] = 32'h7777_1007;
        settle();
        checks++; if (wb_ready !== 4'b0001) begin errors++; $display("FAIL x0_wrap_grant got %b want 0001", wb_ready); end
        tick();
        wb_valid = '0;
        tick();
        settle();
        checks++; if (pending !== 32'h0) begin errors++; $display("FAIL x0_clear7 got %h want 0", pending); end
    endtask

    task automatic test_reset_mid_op;
        iss_valid   = 1'b1;
        iss_uses_rd = 1'b1;
        iss_use_rs  = 3'b000;
        for (int r = 4; r < 8; r++) begin
            iss_rd = 5'(r);
            settle();
            checks++; if (iss_stall !== 1'b0) begin errors++; $display("FAIL mid_issue_%0d got %b want 0", r, iss_stall); end
            tick();
        end
        idle_inputs();
        settle();
        checks++; if (pending !== 32'h0000_00F0) begin errors++; $display("FAIL mid_pending got %h want 000000f0", pending); end
        wb_valid = 4'b0010;
        wb_addr[1*5 +: 5]       = 5'd4;
        wb_data[1*XLEN +: XLEN] = 32'h4444_0004;
        settle();
        checks++; if (wb_ready !== 4'b0010) begin errors++; $display("FAIL mid_grant got %b want 0010", wb_ready); end
        rst = 1'b1;
        settle();
        checks++; if (wb_ready !== 4'b0000) begin errors++; $display("FAIL mid_rst_ready got %b want 0000", wb_ready); end
        tick();
        rst      = 1'b0;
        wb_valid = '0;
        settle();
        checks++; if (pending !== 32'h0 || rf_write !== 1'b0) begin errors++; $display("FAIL mid_after_rst got %h/%b want 0/0", pending, rf_write); end
        wb_valid = 4'b1111;
        settle();
        checks++; if (wb_ready !== 4'b0001) begin errors++; $display("FAIL mid_rr_ptr got %b want 0001", wb_ready); end
        wb_valid = '0;
        tick();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_round_robin();
        test_raw_stall();
        test_waw_stall();
        test_x0_discard();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
